// File: rtl/hazard_fwd_ctrl.sv
// Execute-stage hazard and forwarding controller.
// Tracks the producers in EX and ME and emits registered operand-forwarding
// selects, load-use stall, branch/jump flush and memory-busy freeze controls,
// plus wrap-around stall/flush event counters.
// The WB slot is deliberately not stored: the register file is write-first,
// so a WB producer never needs forwarding, and nothing outside reads it.
module hazard_fwd_ctrl #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1_addr,
  input  logic             id_rs1_ren,
  input  logic [RA_W-1:0]  id_rs2_addr,
  input  logic             id_rs2_ren,
  input  logic [RA_W-1:0]  id_rd_addr,
  input  logic             id_rd_wen,
  input  logic             id_is_load,
  input  logic             ex_b_flag,
  input  logic             ex_jump,
  input  logic             mem_busy,
  output logic [1:0]       rs1_src,
  output logic [1:0]       rs2_src,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic            r_exValid;
  logic [RA_W-1:0] r_exRd;
  logic            r_exWen;
  logic            r_exLoad;
  logic            r_meValid;
  logic [RA_W-1:0] r_meRd;
  logic            r_meWen;

  logic [1:0]       r_rs1Src;
  logic [1:0]       r_rs2Src;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  logic       w_freeze;
  logic       w_redirect;
  logic       w_dep1;
  logic       w_dep2;
  logic       w_loadUse;
  logic       w_flushIdex;
  logic       w_bubble;
  logic       w_fwdEx1;
  logic       w_fwdEx2;
  logic       w_fwdMe1;
  logic       w_fwdMe2;
  logic [1:0] w_rs1SrcNext;
  logic [1:0] w_rs2SrcNext;

  // Hazard detection: freeze dominates redirect, which dominates load-use.
  always_comb begin
    w_freeze    = mem_busy;
    w_redirect  = r_exValid & (ex_b_flag | ex_jump) & ~w_freeze;
    w_dep1      = id_valid & id_rs1_ren & (id_rs1_addr != '0) &
                  r_exValid & r_exWen & r_exLoad & (r_exRd == id_rs1_addr);
    w_dep2      = id_valid & id_rs2_ren & (id_rs2_addr != '0) &
                  r_exValid & r_exWen & r_exLoad & (r_exRd == id_rs2_addr);
    w_loadUse   = (w_dep1 | w_dep2) & ~w_redirect & ~w_freeze;
    w_flushIdex = w_redirect | w_loadUse;
    w_bubble    = w_flushIdex | ~id_valid;
  end

  // Forwarding select for the instruction about to enter EX; the newest producer (EX) wins over ME.
  always_comb begin
    w_fwdEx1 = id_rs1_ren & (id_rs1_addr != '0) & r_exValid & r_exWen & (r_exRd == id_rs1_addr);
    w_fwdEx2 = id_rs2_ren & (id_rs2_addr != '0) & r_exValid & r_exWen & (r_exRd == id_rs2_addr);
    w_fwdMe1 = id_rs1_ren & (id_rs1_addr != '0) & r_meValid & r_meWen & (r_meRd == id_rs1_addr);
    w_fwdMe2 = id_rs2_ren & (id_rs2_addr != '0) & r_meValid & r_meWen & (r_meRd == id_rs2_addr);
    w_rs1SrcNext = 2'b00;
    w_rs2SrcNext = 2'b00;
    if (!w_bubble) begin
      if (w_fwdEx1)      w_rs1SrcNext = 2'b01;
      else if (w_fwdMe1) w_rs1SrcNext = 2'b10;
      if (w_fwdEx2)      w_rs2SrcNext = 2'b01;
      else if (w_fwdMe2) w_rs2SrcNext = 2'b10;
    end
  end

  // Pipeline slot tracking and registered forwarding selects; everything holds while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exValid <= 1'b0;
      r_exRd    <= '0;
      r_exWen   <= 1'b0;
      r_exLoad  <= 1'b0;
      r_meValid <= 1'b0;
      r_meRd    <= '0;
      r_meWen   <= 1'b0;
      r_rs1Src  <= 2'b00;
      r_rs2Src  <= 2'b00;
    end else if (!w_freeze) begin
      r_meValid <= r_exValid;
      r_meRd    <= r_exRd;
      r_meWen   <= r_exWen;
      r_exValid <= id_valid & ~w_flushIdex;
      r_exRd    <= id_rd_addr;
      r_exWen   <= id_rd_wen;
      r_exLoad  <= id_is_load;
      r_rs1Src  <= w_rs1SrcNext;
      r_rs2Src  <= w_rs2SrcNext;
    end
  end

  // Performance counters; both terms already exclude frozen cycles and wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_loadUse)  r_stallCnt <= r_stallCnt + CNT_W'(1);
      if (w_redirect) r_flushCnt <= r_flushCnt + CNT_W'(1);
    end
  end

  assign rs1_src    = r_rs1Src;
  assign rs2_src    = r_rs2Src;
  assign freeze     = w_freeze;
  assign stall_pc   = w_freeze | w_loadUse;
  assign stall_ifid = w_freeze | w_loadUse;
  assign flush_ifid = w_redirect;
  assign flush_idex = w_flushIdex;
  assign stall_cnt  = r_stallCnt;
  assign flush_cnt  = r_flushCnt;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: a table of per-cycle ID/EX
// stimulus with hand-derived expected controls, plus a hand-written
// asynchronous reset sequence.
module tb_hazard_fwd_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 32;

  logic             clock;
  logic             reset;
  logic             idValid;
  logic [RA_W-1:0]  idRs1Addr;
  logic             idRs1Ren;
  logic [RA_W-1:0]  idRs2Addr;
  logic             idRs2Ren;
  logic [RA_W-1:0]  idRdAddr;
  logic             idRdWen;
  logic             idIsLoad;
  logic             exBFlag;
  logic             exJump;
  logic             memBusy;
  logic [1:0]       rs1Src;
  logic [1:0]       rs2Src;
  logic             stallPc;
  logic             stallIfid;
  logic             flushIfid;
  logic             flushIdex;
  logic             freezeOut;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       idv;
    logic [4:0] rs1;
    logic       r1en;
    logic [4:0] rs2;
    logic       r2en;
    logic [4:0] rd;
    logic       wen;
    logic       ld;
    logic       bflag;
    logic       jump;
    logic       busy;
    logic       eStall;
    logic       eFlushIfid;
    logic       eFlushIdex;
    logic       eFreeze;
    logic [1:0] eRs1Src;
    logic [1:0] eRs2Src;
    int         eStallCnt;
    int         eFlushCnt;
  } vec_t;

  typedef struct {
    int         idx;
    logic [1:0] rs1;
    logic [1:0] rs2;
    int         sc;
    int         fc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbQ[$];

  hazard_fwd_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk        (clock),
    .rst        (reset),
    .id_valid   (idValid),
    .id_rs1_addr(idRs1Addr),
    .id_rs1_ren (idRs1Ren),
    .id_rs2_addr(idRs2Addr),
    .id_rs2_ren (idRs2Ren),
    .id_rd_addr (idRdAddr),
    .id_rd_wen  (idRdWen),
    .id_is_load (idIsLoad),
    .ex_b_flag  (exBFlag),
    .ex_jump    (exJump),
    .mem_busy   (memBusy),
    .rs1_src    (rs1Src),
    .rs2_src    (rs2Src),
    .stall_pc   (stallPc),
    .stall_ifid (stallIfid),
    .flush_ifid (flushIfid),
    .flush_idex (flushIdex),
    .freeze     (freezeOut),
    .stall_cnt  (stallCnt),
    .flush_cnt  (flushCnt)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic idv, int rs1, logic r1en, int rs2, logic r2en,
                              int rd, logic wen, logic ld, logic bflag, logic jump,
                              logic busy, logic eStall, logic eFi, logic eFx, logic eFz,
                              logic [1:0] eR1, logic [1:0] eR2, int eSc, int eFc);
    vec_t v;
    v.idv = idv; v.rs1 = 5'(rs1); v.r1en = r1en; v.rs2 = 5'(rs2); v.r2en = r2en;
    v.rd = 5'(rd); v.wen = wen; v.ld = ld; v.bflag = bflag; v.jump = jump; v.busy = busy;
    v.eStall = eStall; v.eFlushIfid = eFi; v.eFlushIdex = eFx; v.eFreeze = eFz;
    v.eRs1Src = eR1; v.eRs2Src = eR2; v.eStallCnt = eSc; v.eFlushCnt = eFc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    idValid   = v.idv;
    idRs1Addr = v.rs1;
    idRs1Ren  = v.r1en;
    idRs2Addr = v.rs2;
    idRs2Ren  = v.r2en;
    idRdAddr  = v.rd;
    idRdWen   = v.wen;
    idIsLoad  = v.ld;
    exBFlag   = v.bflag;
    exJump    = v.jump;
    memBusy   = v.busy;
  endtask

  initial begin
    sb_t e;
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

    //        idv rs1 en rs2 en rd wen ld  bf jp bsy | stl fi fx fz  rs1    rs2    sc fc
    vecs.push_back(mk(1,  1, 1,  2, 1,  5, 1, 0,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 0, 0)); // add x5
    vecs.push_back(mk(1,  5, 1,  3, 1,  9, 1, 0,  0, 0, 0,   0, 0, 0, 0, 2'b01, 2'b00, 0, 0)); // use x5 -> 01
    vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 0, 0)); // nop
    vecs.push_back(mk(1,  1, 1,  2, 1,  6, 1, 0,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 0, 0)); // add x6
    vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 0, 0)); // nop
    vecs.push_back(mk(1,  3, 1,  6, 1, 10, 1, 0,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b10, 0, 0)); // dist 2 -> 10
    vecs.push_back(mk(1,  1, 1,  0, 0,  7, 1, 1,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 0, 0)); // ld x7
    vecs.push_back(mk(1,  7, 1,  2, 1, 11, 1, 0,  0, 0, 0,   1, 0, 1, 0, 2'b00, 2'b00, 1, 0)); // load-use stall
    vecs.push_back(mk(1,  7, 1,  2, 1, 11, 1, 0,  0, 0, 0,   0, 0, 0, 0, 2'b10, 2'b00, 1, 0)); // replay -> 10
    vecs.push_back(mk(1,  1, 1,  2, 1,  8, 1, 0,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 1, 0)); // add x8
    vecs.push_back(mk(1,  3, 1,  4, 1,  8, 1, 0,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 1, 0)); // add x8 again
    vecs.push_back(mk(1,  8, 1,  8, 1, 12, 1, 0,  0, 0, 0,   0, 0, 0, 0, 2'b01, 2'b01, 1, 0)); // EX beats ME
    vecs.push_back(mk(1,  1, 1,  2, 1,  0, 1, 0,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 1, 0)); // add x0
    vecs.push_back(mk(1,  1, 1,  0, 0,  0, 1, 1,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 1, 0)); // ld x0
    vecs.push_back(mk(1,  0, 1,  0, 1, 13, 1, 0,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 1, 0)); // read x0
    vecs.push_back(mk(1,  1, 1,  0, 0, 14, 1, 1,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 1, 0)); // ld x14
    vecs.push_back(mk(1, 14, 1, 14, 1, 15, 1, 0,  1, 0, 0,   0, 1, 1, 0, 2'b00, 2'b00, 1, 1)); // branch beats load-use
    vecs.push_back(mk(1, 14, 1,  0, 0, 16, 1, 0,  0, 1, 0,   0, 0, 0, 0, 2'b10, 2'b00, 1, 1)); // jump, EX empty
    vecs.push_back(mk(0,  0, 0,  0, 0,  0, 0, 0,  0, 1, 0,   0, 1, 1, 0, 2'b00, 2'b00, 1, 2)); // jump redirect
    vecs.push_back(mk(1, 16, 1,  0, 0, 17, 1, 1,  0, 0, 0,   0, 0, 0, 0, 2'b10, 2'b00, 1, 2)); // ld x17 <- x16
    vecs.push_back(mk(1,  2, 1, 17, 1, 18, 1, 0,  0, 0, 1,   1, 0, 0, 1, 2'b10, 2'b00, 1, 2)); // frozen
    vecs.push_back(mk(1,  2, 1, 17, 1, 18, 1, 0,  1, 0, 1,   1, 0, 0, 1, 2'b10, 2'b00, 1, 2)); // frozen, branch deferred
    vecs.push_back(mk(1,  2, 1, 17, 1, 18, 1, 0,  0, 0, 1,   1, 0, 0, 1, 2'b10, 2'b00, 1, 2)); // frozen
    vecs.push_back(mk(1,  2, 1, 17, 1, 18, 1, 0,  0, 0, 0,   1, 0, 1, 0, 2'b00, 2'b00, 2, 2)); // load-use resumes
    vecs.push_back(mk(1,  2, 1, 17, 1, 18, 1, 0,  0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b10, 2, 2)); // replay -> 10

    reset = 1'b1;
    applyStimulus(idle);
    #1;
    checkOutput("reset rs1_src", rs1Src, 0);
    checkOutput("reset rs2_src", rs2Src, 0);
    checkOutput("reset stall_pc", stallPc, 0);
    checkOutput("reset flush_idex", flushIdex, 0);
    checkOutput("reset stall_cnt", stallCnt, 0);
    checkOutput("reset flush_cnt", flushCnt, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d stall_pc", i), stallPc, vecs[i].eStall);
      checkOutput($sformatf("v%0d stall_ifid", i), stallIfid, vecs[i].eStall);
      checkOutput($sformatf("v%0d flush_ifid", i), flushIfid, vecs[i].eFlushIfid);
      checkOutput($sformatf("v%0d flush_idex", i), flushIdex, vecs[i].eFlushIdex);
      checkOutput($sformatf("v%0d freeze", i), freezeOut, vecs[i].eFreeze);
      sbQ.push_back('{idx: i, rs1: vecs[i].eRs1Src, rs2: vecs[i].eRs2Src,
                      sc: vecs[i].eStallCnt, fc: vecs[i].eFlushCnt});
      @(posedge clock);
      #1;
      e = sbQ.pop_front();
      checkOutput($sformatf("v%0d rs1_src", e.idx), rs1Src, e.rs1);
      checkOutput($sformatf("v%0d rs2_src", e.idx), rs2Src, e.rs2);
      checkOutput($sformatf("v%0d stall_cnt", e.idx), stallCnt, e.sc);
      checkOutput($sformatf("v%0d flush_cnt", e.idx), flushCnt, e.fc);
    end

    // Mid-stream async reset: EX holds add x18, a taken branch is pending.
    @(negedge clock);
    applyStimulus(mk(1, 18, 1, 0, 0, 20, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    #1;
    checkOutput("pre-reset flush_ifid", flushIfid, 1);
    checkOutput("pre-reset rs2_src", rs2Src, 2);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("async reset flush_ifid", flushIfid, 0);
    checkOutput("async reset flush_idex", flushIdex, 0);
    checkOutput("async reset stall_pc", stallPc, 0);
    checkOutput("async reset rs2_src", rs2Src, 0);
    checkOutput("async reset stall_cnt", stallCnt, 0);
    checkOutput("async reset flush_cnt", flushCnt, 0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(mk(1, 18, 1, 0, 0, 20, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    #1;
    checkOutput("post-reset flush_ifid", flushIfid, 0);
    @(posedge clock);
    #1;
    checkOutput("post-reset rs1_src", rs1Src, 0);
    checkOutput("post-reset flush_cnt", flushCnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
